adc_sample_sequencer: RTL and testbench
=======================================

// Module: adc_sample_sequencer
// PURPOSE
//  Paces conversions of the ADC array for the trigger/storage controller (tsc): issues periodic req/rdy
//  handshakes at a programmable rate and timestamps each sample. Presents samples as one-cycle valid strobes.
//  Detects a stuck ADC, recovers it via the ADC reset line, and flags dropped sample ticks.
// PARAMETERS
//  DATA_W   8    ADC sample width
//  DIV_W    16   width of the sample-period register
//  TS_W     32   timestamp width
//  TIMEOUT  64   max cycles from req rise to rdy rise before recovery
//  RST_LEN  4    cycles adc_rst is held high during recovery
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  reset        in   1       synchronous, active-low reset
//  start        in   1       begin sampling (sampled in IDLE only)
//  stop         in   1       end sampling after the current handshake
//  period       in   DIV_W   cycles between sample ticks; 0 is treated as 1; sampled on start
//  clear_err    in   1       clears the timeout_err and overrun sticky flags
//  rdy          in   1       ADC ready
//  dat          in   DATA_W  ADC data, valid while rdy=1
//  req          out  1       conversion request to ADC
//  adc_rst      out  1       ADC reset pulse
//  smp_dat      out  DATA_W  captured sample
//  smp_ts       out  TS_W    timestamp of the tick that launched smp_dat
//  smp_valid    out  1       one-cycle strobe; smp_dat and smp_ts are valid
//  busy         out  1       high in every state except IDLE
//  timeout_err  out  1       sticky: ADC failed to answer within TIMEOUT
//  overrun      out  1       sticky: a tick arrived while a handshake was pending
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE. All outputs 0, tick counter 0, timestamp counter 0.
//   Reset overrides everything, including mid-handshake and mid-recovery states.
//  Timestamp counter (TS_W bits): free-running from reset, +1 per cycle, wraps modulo 2^TS_W.
//  States:
//   IDLE:    start=1 -> latch period (0 becomes 1), load tick counter = 0, go REQ.
//            First req rises on the edge after start is seen. Latch ts at that edge.
//   REQ:     req=1. rdy=1 -> capture dat into smp_dat, req=0 next cycle, smp_valid=1 for one cycle, go RELEASE.
//            No rdy within TIMEOUT cycles of req rise -> req=0, go RECOVER.
//   RELEASE: wait for rdy=0 (four-phase handshake).
//            rdy=0 -> stop seen since launch ? IDLE : WAIT_TICK.
//   WAIT_TICK: a tick fires once tick counter reaches period-1 -> go REQ and latch ts.
//   RECOVER: adc_rst=1 for RST_LEN cycles, then timeout_err=1, then WAIT_TICK
//            (or IDLE if stop has been seen). No smp_valid is issued for the lost sample.
//  Tick counter: runs continuously while busy; req-rise to req-rise spacing = period when the ADC keeps up.
//  Overrun: a tick that fires in REQ, RELEASE or RECOVER is dropped and sets overrun=1.
//   The next sample waits for the next tick.
//  stop: sticky until IDLE. Never aborts an active handshake.
//   stop in WAIT_TICK -> IDLE on the next edge, with no further req.
//  start while busy: ignored. start and stop together in IDLE: start wins, and the sequencer stops after one sample.
//  Flag priority: clear_err and a new set in the same cycle -> the flag ends at 1 (set wins).
//  Latency: rdy rise -> smp_valid is 1 cycle. smp_dat and smp_ts hold their values until the next capture.
// TESTING
//  1 period=5, ADC answers rdy 2 cycles after req: req rises every 5 cycles; smp_valid 1 cycle after rdy;
//    smp_ts increments by 5.
//  2 period=0: behaves as period=1. ADC answering in 3 cycles -> overrun=1 and samples are spaced by handshake length.
//  3 rdy held 0 with TIMEOUT=64: req falls after 64 cycles; adc_rst high for 4 cycles; timeout_err=1; no smp_valid;
//    clear_err -> 0.
//  4 stop raised mid-REQ, dat=8'hD5: the handshake completes, smp_dat=8'hD5, then IDLE with busy=0 and no further req.
//  5 reset=0 during REQ and again during RECOVER: on the next edge req=0, adc_rst=0, all flags 0, state IDLE.
//  6 timestamp counter preloaded near 2^32-1: smp_ts wraps to small values with no glitch on smp_valid.

Source files
------------

// File: rtl/adc_sample_sequencer_if.sv
// ADC conversion handshake bundle: request/reset toward the converter, ready/data back.
interface adc_sample_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              req;
    logic              adc_rst;
    logic              rdy;
    logic [DATA_W-1:0] dat;

    modport master (output req, output adc_rst, input rdy, input dat);
    modport slave  (input req, input adc_rst, output rdy, output dat);
endinterface

// File: rtl/adc_sample_sequencer.sv
// Paces ADC conversions at a programmable tick rate, timestamps each sample,
// recovers a stuck converter through its reset line and flags dropped ticks.
module adc_sample_sequencer #(
    parameter int DATA_W  = 8,
    parameter int DIV_W   = 16,
    parameter int TS_W    = 32,
    parameter int TIMEOUT = 64,
    parameter int RST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [DIV_W-1:0]       i_period,
    input  logic                   i_clear_err,
    adc_sample_sequencer_if.master adc,
    output logic [DATA_W-1:0]      o_smp_dat,
    output logic [TS_W-1:0]        o_smp_ts,
    output logic                   o_smp_valid,
    output logic                   o_busy,
    output logic                   o_timeout_err,
    output logic                   o_overrun
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ       = 3'd1;
    localparam logic [2:0] S_RELEASE   = 3'd2;
    localparam logic [2:0] S_WAIT_TICK = 3'd3;
    localparam logic [2:0] S_RECOVER   = 3'd4;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int RL_W = $clog2(RST_LEN + 1);

    logic [2:0]        r_state;
    logic [DIV_W-1:0]  r_period;
    logic [DIV_W-1:0]  r_tick_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [RL_W-1:0]   r_rst_cnt;
    logic [TS_W-1:0]   r_ts;
    logic [TS_W-1:0]   r_launch_ts;
    logic              r_stop_seen;
    logic              r_req;
    logic              r_adc_rst;
    logic [DATA_W-1:0] r_smp_dat;
    logic [TS_W-1:0]   r_smp_ts;
    logic              r_smp_valid;
    logic              r_busy;
    logic              r_timeout_err;
    logic              r_overrun;

    logic [2:0]        w_next;
    logic              w_tick;
    logic              w_stop;
    logic              w_launch;
    logic              w_capture;
    logic              w_to_set;
    logic              w_ovr_set;

    // Next-state decode; a stop request never interrupts a handshake in flight.
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_capture = 1'b0;
        w_to_set  = 1'b0;
        w_tick    = (r_tick_cnt == (r_period - DIV_W'(1)));
        w_stop    = r_stop_seen | i_stop;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next   = S_REQ;
                    w_launch = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (adc.rdy) begin
                    w_next    = S_RELEASE;
                    w_capture = 1'b1;
                end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_next = S_RECOVER;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_RELEASE: begin
                if (!adc.rdy) begin
                    w_next = w_stop ? S_IDLE : S_WAIT_TICK;
                end else begin
                    w_next = S_RELEASE;
                end
            end
            S_WAIT_TICK: begin
                if (w_stop) begin
                    w_next = S_IDLE;
                end else if (w_tick) begin
                    w_next   = S_REQ;
                    w_launch = 1'b1;
                end else begin
                    w_next = S_WAIT_TICK;
                end
            end
            S_RECOVER: begin
                if (r_rst_cnt == RL_W'(RST_LEN - 1)) begin
                    w_next   = w_stop ? S_IDLE : S_WAIT_TICK;
                    w_to_set = 1'b1;
                end else begin
                    w_next = S_RECOVER;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        w_ovr_set = w_tick & ((r_state == S_REQ) | (r_state == S_RELEASE) | (r_state == S_RECOVER));
    end

    // State, counters and registered outputs; reset overrides every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_period      <= DIV_W'(1);
            r_tick_cnt    <= '0;
            r_to_cnt      <= '0;
            r_rst_cnt     <= '0;
            r_ts          <= '0;
            r_launch_ts   <= '0;
            r_stop_seen   <= 1'b0;
            r_req         <= 1'b0;
            r_adc_rst     <= 1'b0;
            r_smp_dat     <= '0;
            r_smp_ts      <= '0;
            r_smp_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_ts        <= r_ts + TS_W'(1);
            r_state     <= w_next;
            r_req       <= (w_next == S_REQ);
            r_adc_rst   <= (w_next == S_RECOVER);
            r_busy      <= (w_next != S_IDLE);
            r_smp_valid <= w_capture;
            r_to_cnt    <= (r_state == S_REQ) ? (r_to_cnt + TO_W'(1)) : '0;
            r_rst_cnt   <= (r_state == S_RECOVER) ? (r_rst_cnt + RL_W'(1)) : '0;
            if (w_capture) begin
                r_smp_dat <= adc.dat;
                r_smp_ts  <= r_launch_ts;
            end
            if (w_launch) begin
                r_launch_ts <= r_ts;
            end
            // The tick phase is anchored to the start edge so req spacing equals the period.
            if (r_state == S_IDLE) begin
                r_tick_cnt <= '0;
                if (i_start) begin
                    r_period <= (i_period == '0) ? DIV_W'(1) : i_period;
                end
            end else begin
                r_tick_cnt <= w_tick ? '0 : (r_tick_cnt + DIV_W'(1));
            end
            if (w_next == S_IDLE) begin
                r_stop_seen <= 1'b0;
            end else if (i_stop) begin
                r_stop_seen <= 1'b1;
            end
            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (i_clear_err) begin
                r_timeout_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (i_clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign adc.req       = r_req;
    assign adc.adc_rst   = r_adc_rst;
    assign o_smp_dat     = r_smp_dat;
    assign o_smp_ts      = r_smp_ts;
    assign o_smp_valid   = r_smp_valid;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
    assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench: an edge-indexed reference model predicts launches, samples and flags;
// a separate monitor compares DUT outputs against it every cycle.
module tb_adc_sample_sequencer;
    localparam int DATA_W  = 8;
    localparam int DIV_W   = 16;
    localparam int TS_W    = 10;
    localparam int TIMEOUT = 64;
    localparam int RST_LEN = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              clear_err = 1'b0;
    logic [DIV_W-1:0]  period = '0;
    logic [DATA_W-1:0] smp_dat;
    logic [TS_W-1:0]   smp_ts;
    logic              smp_valid;
    logic              busy;
    logic              timeout_err;
    logic              overrun;

    adc_sample_sequencer_if #(.DATA_W(DATA_W)) adc_if ();

    adc_sample_sequencer #(
        .DATA_W(DATA_W), .DIV_W(DIV_W), .TS_W(TS_W), .TIMEOUT(TIMEOUT), .RST_LEN(RST_LEN)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_stop(stop), .i_period(period),
        .i_clear_err(clear_err), .adc(adc_if), .o_smp_dat(smp_dat), .o_smp_ts(smp_ts),
        .o_smp_valid(smp_valid), .o_busy(busy), .o_timeout_err(timeout_err), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] dat;
        logic [TS_W-1:0]   ts;
        int                due;
    } exp_t;
    exp_t sb[$];

    // Stimulus knobs read by the ADC model at each launch; adc_d == 0 means the ADC never answers.
    int          adc_d = 2;
    bit          force_en = 1'b0;
    logic [7:0]  force_dat = 8'hD5;

    // Reference model state, indexed by posedge count since the last reset edge.
    int E = 0, S = 0, P = 1, L = 0, A = 0, REQ_END = 0, C = 0;
    bit m_busy = 0, m_in_hs = 0, m_to = 0, m_stopf = 0;
    bit m_req = 0, m_arst = 0, m_ovr = 0, m_terr = 0;
    logic [DATA_W-1:0] m_dat = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, E);
        end
    endtask

    task automatic launch();
        exp_t it;
        L       = E;
        m_in_hs = 1'b1;
        m_req   = 1'b1;
        m_to    = (adc_d == 0);
        if (m_to) begin
            REQ_END = L + TIMEOUT;
            C       = L + TIMEOUT + RST_LEN;
        end else begin
            A       = L + adc_d;
            REQ_END = A;
            C       = A + 1;
            m_dat   = force_en ? force_dat : DATA_W'($urandom);
            it.dat  = m_dat;
            it.ts   = TS_W'(L - 1);
            it.due  = A;
            sb.push_back(it);
        end
    endtask

    // Reference model: ticks every P edges after the start edge; a tick during a handshake is dropped.
    initial begin
        bit tick, set_o, set_t;
        forever begin
            @(posedge clk);
            E = reset ? E + 1 : 0;
            if (!reset) begin
                m_busy = 0; m_in_hs = 0; m_req = 0; m_arst = 0; m_ovr = 0; m_terr = 0;
                sb.delete();
            end else begin
                set_o = 0;
                set_t = 0;
                if (!m_busy) begin
                    if (start) begin
                        m_busy  = 1;
                        S       = E;
                        P       = (period == 0) ? 1 : int'(period);
                        m_stopf = stop;
                        launch();
                    end
                end else begin
                    tick = ((E - S) % P) == 0;
                    if (m_in_hs) begin
                        if (stop) m_stopf = 1;
                        if (tick) set_o = 1;
                        if (E == REQ_END) m_req = 0;
                        if (m_to && E == L + TIMEOUT) m_arst = 1;
                        if (E == C) begin
                            m_in_hs = 0;
                            m_arst  = 0;
                            if (m_to) set_t = 1;
                            if (m_stopf) m_busy = 0;
                        end
                    end else if (stop) begin
                        m_busy = 0;
                    end else if (tick) begin
                        launch();
                    end
                end
                m_ovr  = set_o | (m_ovr & !clear_err);
                m_terr = set_t | (m_terr & !clear_err);
            end
        end
    end

    // ADC responder: raises rdy for the single cycle the model expects it sampled.
    initial begin
        adc_if.rdy = 1'b0;
        adc_if.dat = '0;
        forever begin
            @(negedge clk);
            adc_if.rdy = m_in_hs && !m_to && (E == A - 1);
            if (adc_if.rdy) adc_if.dat = m_dat;
        end
    end

    // Monitor: control levels every cycle, samples popped from the scoreboard on each strobe.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #1;
            check("levels{req,arst,busy,ovr,terr}",
                  {adc_if.req, adc_if.adc_rst, busy, overrun, timeout_err},
                  {m_req, m_arst, m_busy, m_ovr, m_terr});
            if (smp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_smp_valid", 1, 0);
                end else begin
                    it = sb.pop_front();
                    check("smp_dat", smp_dat, it.dat);
                    check("smp_ts", smp_ts, it.ts);
                    check("smp_valid_edge", E, it.due);
                end
            end
            while (sb.size() > 0 && sb[0].due < E) begin
                check("missing_smp_valid_edge", E, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1; cyc(1); clear_err = 1'b0;
    endtask

    initial begin
        cyc(3);
        #2;
        check("reset_smp_dat", smp_dat, 0);
        check("reset_smp_ts", smp_ts, 0);
        check("reset_busy", busy, 0);
        reset = 1'b1;
        cyc(2);

        // period 5, ADC answers after 2 cycles
        period = 16'd5; adc_d = 2;
        pulse_start(); cyc(40); pulse_stop(); cyc(10);

        // period 0 behaves as 1; slow ADC overruns
        period = 16'd0; adc_d = 3;
        pulse_start(); cyc(20);
        #2 check("period0_overrun", overrun, 1);
        pulse_stop(); cyc(10); pulse_clear(); cyc(2);

        // stuck ADC: timeout, recovery pulse, sticky error, then clear
        period = 16'd100; adc_d = 0;
        pulse_start(); cyc(75);
        #2 check("timeout_err_set", timeout_err, 1);
        pulse_stop(); cyc(3); pulse_clear(); cyc(1);
        #2 check("timeout_err_cleared", timeout_err, 0);

        // stop mid-REQ completes the handshake with dat D5
        period = 16'd8; adc_d = 4; force_en = 1'b1;
        pulse_start(); cyc(2); pulse_stop(); cyc(12);
        #2 check("stop_mid_req_dat", smp_dat, 8'hD5);
        force_en = 1'b0;

        // reset during REQ, then during RECOVER
        period = 16'd3; adc_d = 5;
        pulse_start(); cyc(2);
        reset = 1'b0; cyc(1); reset = 1'b1; cyc(3);
        period = 16'd50; adc_d = 0;
        pulse_start(); cyc(66);
        reset = 1'b0; cyc(1); reset = 1'b1; cyc(3);

        // start and stop together, then stop while waiting for a tick
        period = 16'd4; adc_d = 2;
        start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0; cyc(15);
        period = 16'd30;
        pulse_start(); cyc(10); pulse_stop(); cyc(5);

        // randomized traffic long enough for the timestamp to wrap
        for (int i = 0; i < 1600; i++) begin
            start     = ($urandom_range(15) == 0);
            stop      = ($urandom_range(39) == 0);
            clear_err = ($urandom_range(19) == 0);
            period    = DIV_W'($urandom_range(9));
            adc_d     = $urandom_range(11);
            cyc(1);
        end
        start = 1'b0; clear_err = 1'b0; stop = 1'b1; adc_d = 2;
        cyc(1);
        stop = 1'b0;
        cyc(100);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
